filter_job_scheduler: RTL and testbench

Sequences frame-filtering jobs for the 3x3 filtering control unit (FCU). Accepts job descriptors (frame width, height, kernel select) into a 4-entry FIFO and loads the selected kernel's 9 coefficients from the coefficient ROM into the MAC wrapper. It then starts the FCU, waits for its done, and reports completion, timeout and abort per job. It sits between the host/register block and the FCU plus MAC wrapper.

---
 rtl/filter_job_scheduler.sv | 229 ++++++++++++++++++++++
 tb/tb_filter_job_scheduler.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_job_scheduler.sv
`timescale 1ns/1ps
// filter_job_scheduler: queues frame-filtering jobs, loads the selected 3x3
// kernel from the coefficient ROM into the MAC wrapper, runs the FCU and
// reports per-job completion, timeout and abort.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a queued descriptor; pops and decodes it
// LOAD_COEF | streaming 9 coefficients ROM -> MAC wrapper (10 cycles)
// START     | fcu_start pulse, dimensions presented to the FCU
// BLANK     | 2 cycles ignoring fcu_done (may still be high from last frame)
// RUN       | waiting for fcu_done; watchdog counting
// DRAIN     | job failed; waiting for the FCU to finish before retiring
// FINISH    | retire the job: job_done/job_error, completion counter
module filter_job_scheduler #(
  parameter int DIMM_BUS_WIDTH = 16,
  parameter int COEF_WIDTH     = 8,
  parameter int WDOG_WIDTH     = 24
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      job_valid,
  output logic                      job_ready,
  input  logic [DIMM_BUS_WIDTH-1:0] job_width,
  input  logic [DIMM_BUS_WIDTH-1:0] job_height,
  input  logic [1:0]                job_kernel_sel,
  input  logic                      abort,
  input  logic [WDOG_WIDTH-1:0]     cfg_timeout,
  output logic [5:0]                rom_addr,
  input  logic [COEF_WIDTH-1:0]     rom_data,
  output logic                      coef_we,
  output logic [3:0]                coef_idx,
  output logic [COEF_WIDTH-1:0]     coef_data,
  output logic                      fcu_start,
  output logic [DIMM_BUS_WIDTH-1:0] fcu_width,
  output logic [DIMM_BUS_WIDTH-1:0] fcu_height,
  input  logic                      fcu_done,
  output logic                      busy,
  output logic                      job_done,
  output logic                      job_error,
  output logic [15:0]               jobs_completed
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_COEF, S_START, S_BLANK, S_RUN, S_DRAIN, S_FINISH
  } state_t;

  localparam int DEPTH = 4;

  state_t state;

  logic [DIMM_BUS_WIDTH-1:0] fifo_w [DEPTH];
  logic [DIMM_BUS_WIDTH-1:0] fifo_h [DEPTH];
  logic [1:0]                fifo_k [DEPTH];
  logic [1:0]                wr_ptr, rd_ptr;
  logic [2:0]                count;
  logic                      full, push, pop;

  logic [DIMM_BUS_WIDTH-1:0] head_w, head_h;
  logic [1:0]                head_k;

  logic [DIMM_BUS_WIDTH-1:0] job_w, job_h;
  logic [1:0]                job_k;
  logic [1:0]                cache_k;
  logic                      cache_valid;
  logic                      err;
  logic [3:0]                cnt;
  logic [WDOG_WIDTH-1:0]     wdog;

  assign full      = (count == 3'd4);
  assign job_ready = !full;
  // abort wins over a same-cycle push and blocks the pop so the flush is total
  assign push      = job_valid && !full && !abort;
  assign pop       = (state == S_IDLE) && (count != 3'd0) && !abort;

  assign head_w = fifo_w[rd_ptr];
  assign head_h = fifo_h[rd_ptr];
  assign head_k = fifo_k[rd_ptr];

  assign busy      = (state != S_IDLE) || (count != 3'd0);
  // ROM data already lags its address by one cycle, so it lines up with coef_we
  assign coef_data = coef_we ? rom_data : '0;

  // Descriptor FIFO: 4 entries, flushed entirely by abort
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_w[i] <= '0;
        fifo_h[i] <= '0;
        fifo_k[i] <= '0;
      end
    end else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_w[wr_ptr] <= job_width;
        fifo_h[wr_ptr] <= job_height;
        fifo_k[wr_ptr] <= job_kernel_sel;
        wr_ptr         <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b00, push} - {2'b00, pop};
    end
  end

  // Job sequencing FSM with registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= S_IDLE;
      job_w          <= '0;
      job_h          <= '0;
      job_k          <= '0;
      cache_k        <= '0;
      cache_valid    <= 1'b0;
      err            <= 1'b0;
      cnt            <= '0;
      wdog           <= '0;
      rom_addr       <= '0;
      coef_we        <= 1'b0;
      coef_idx       <= '0;
      fcu_start      <= 1'b0;
      fcu_width      <= '0;
      fcu_height     <= '0;
      job_done       <= 1'b0;
      job_error      <= 1'b0;
      jobs_completed <= '0;
    end else begin
      fcu_start <= 1'b0;
      job_done  <= 1'b0;
      job_error <= 1'b0;
      coef_we   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            job_w <= head_w;
            job_h <= head_h;
            job_k <= head_k;
            err   <= 1'b0;
            if (head_w == '0 || head_h == '0) begin
              err   <= 1'b1;
              state <= S_FINISH;
            end else if (cache_valid && cache_k == head_k) begin
              fcu_start  <= 1'b1;
              fcu_width  <= head_w;
              fcu_height <= head_h;
              state      <= S_START;
            end else begin
              // the bank is about to be overwritten, so it is not trustworthy
              cache_valid <= 1'b0;
              rom_addr    <= {head_k, 4'd0};
              cnt         <= '0;
              state       <= S_LOAD_COEF;
            end
          end
        end
        S_LOAD_COEF: begin
          if (abort) begin
            cache_valid <= 1'b0;
            err         <= 1'b1;
            state       <= S_FINISH;
          end else begin
            cnt <= cnt + 4'd1;
            if (cnt < 4'd8) rom_addr <= {job_k, cnt + 4'd1};
            if (cnt <= 4'd8) begin
              coef_we  <= 1'b1;
              coef_idx <= cnt;
            end
            if (cnt == 4'd9) begin
              cache_k     <= job_k;
              cache_valid <= 1'b1;
              fcu_start   <= 1'b1;
              fcu_width   <= job_w;
              fcu_height  <= job_h;
              state       <= S_START;
            end
          end
        end
        S_START: begin
          cnt <= '0;
          if (abort) begin
            err   <= 1'b1;
            state <= S_DRAIN;
          end else begin
            state <= S_BLANK;
          end
        end
        S_BLANK: begin
          if (abort) begin
            err   <= 1'b1;
            state <= S_DRAIN;
          end else if (cnt == 4'd1) begin
            wdog  <= '0;
            state <= S_RUN;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_RUN: begin
          wdog <= wdog + WDOG_WIDTH'(1);
          if (abort) begin
            err   <= 1'b1;
            state <= S_DRAIN;
          end else if (fcu_done) begin
            state <= S_FINISH;
          end else if (cfg_timeout != '0 && wdog + WDOG_WIDTH'(1) == cfg_timeout) begin
            err   <= 1'b1;
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (fcu_done) state <= S_FINISH;
        end
        S_FINISH: begin
          job_done  <= 1'b1;
          job_error <= err;
          if (!err) jobs_completed <= jobs_completed + 16'd1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_filter_job_scheduler.sv
`timescale 1ns/1ps
// Directed bench for filter_job_scheduler: ROM and FCU are modelled here,
// outputs are sampled on the falling edge.
module tb_filter_job_scheduler;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [15:0] job_width = '0, job_height = '0;
  logic [1:0]  job_kernel_sel = '0;
  logic        abort = 1'b0;
  logic [23:0] cfg_timeout = '0;
  logic [5:0]  rom_addr;
  logic [7:0]  rom_data = '0;
  logic        coef_we;
  logic [3:0]  coef_idx;
  logic [7:0]  coef_data;
  logic        fcu_start;
  logic [15:0] fcu_width, fcu_height;
  logic        fcu_done = 1'b0;
  logic        busy, job_done, job_error;
  logic [15:0] jobs_completed;

  int n_checks = 0;
  int n_fail   = 0;
  int n_start = 0, n_done = 0, n_err = 0, n_coef = 0;
  int last_w = 0;

  filter_job_scheduler dut (
    .clk(clk), .resetn(resetn),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_width(job_width), .job_height(job_height), .job_kernel_sel(job_kernel_sel),
    .abort(abort), .cfg_timeout(cfg_timeout),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .coef_we(coef_we), .coef_idx(coef_idx), .coef_data(coef_data),
    .fcu_start(fcu_start), .fcu_width(fcu_width), .fcu_height(fcu_height),
    .fcu_done(fcu_done), .busy(busy), .job_done(job_done), .job_error(job_error),
    .jobs_completed(jobs_completed)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_f(input int a);
    return 8'((a * 3) + 5);
  endfunction

  // coefficient ROM, one cycle read latency
  always @(posedge clk) rom_data <= rom_f(int'(rom_addr));

  // pulse counters; at posedge the outputs still hold the ending cycle's values
  always @(posedge clk) begin
    if (resetn) begin
      if (fcu_start) begin
        n_start++;
        last_w = int'(fcu_width);
      end
      if (job_done) n_done++;
      if (job_done && job_error) n_err++;
      if (coef_we) n_coef++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input int w, input int h, input int k);
    job_width      = 16'(w);
    job_height     = 16'(h);
    job_kernel_sel = 2'(k);
    job_valid      = 1'b1;
    step();
    job_valid      = 1'b0;
  endtask

  // which: 0 = fcu_start, 1 = job_done; cyc = -1 if the bound expires
  task automatic wait_for(input int which, input int max, output int cyc);
    int i;
    i   = 0;
    cyc = -1;
    while (cyc < 0 && i < max) begin
      i++;
      step();
      if ((which == 0 && fcu_start) || (which == 1 && job_done)) cyc = i;
    end
  endtask

  initial begin
    int cyc, s0, d0, c0, e0;

    // reset values
    repeat (3) step();
    chk("rst_job_ready", job_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_fcu_start", fcu_start, 0);
    chk("rst_job_done", job_done, 0);
    chk("rst_completed", jobs_completed, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_coef_data", coef_data, 0);
    resetn = 1'b1;
    step();

    // cold cache, kernel 1
    push(8, 4, 1);
    for (int c = 1; c <= 12; c++) begin
      if (c >= 2 && c <= 10) chk("cold_rom_addr", rom_addr, 16 + c - 2);
      if (c >= 3 && c <= 11) begin
        chk("cold_coef_we", coef_we, 1);
        chk("cold_coef_idx", coef_idx, c - 3);
        chk("cold_coef_data", coef_data, rom_f(16 + c - 3));
      end
      if (c == 1 || c == 12) chk("cold_coef_we_off", coef_we, 0);
      if (c == 11) chk("cold_start_early", fcu_start, 0);
      if (c == 12) begin
        chk("cold_start", fcu_start, 1);
        chk("cold_fcu_width", fcu_width, 8);
        chk("cold_fcu_height", fcu_height, 4);
      end
      if (c < 12) step();
    end
    repeat (50) step();
    fcu_done = 1'b1;
    wait_for(1, 10, cyc);
    chk("t1_done_latency", cyc, 2);
    chk("t1_job_error", job_error, 0);
    chk("t1_completed", jobs_completed, 1);

    // two k=2 jobs back-to-back, fcu_done left high (stale) throughout
    push(16, 8, 2);
    push(10, 6, 2);
    wait_for(0, 20, cyc);
    chk("t2_cold_start", cyc, 10);
    c0 = n_coef;
    wait_for(1, 10, cyc);
    chk("t2_blank_ignores_stale", cyc, 5);
    chk("t2_completed_a", jobs_completed, 2);
    wait_for(0, 5, cyc);
    chk("t2_warm_start", cyc, 1);
    chk("t2_fcu_width", fcu_width, 10);
    chk("t2_fcu_height", fcu_height, 6);
    wait_for(1, 10, cyc);
    chk("t2_done_b", cyc, 5);
    chk("t2_no_reload", n_coef - c0, 0);
    chk("t2_completed_b", jobs_completed, 3);

    // FIFO full: blocker job holds the FSM in RUN while 5 pushes are offered
    fcu_done = 1'b0;
    push(20, 20, 2);
    wait_for(0, 5, cyc);
    chk("t3_blocker_start", cyc, 1);
    d0 = n_done;
    e0 = n_err;
    for (int i = 1; i <= 5; i++) begin
      chk("t3_ready_before_push", job_ready, (i <= 4) ? 1 : 0);
      push(i, i, 2);
    end
    chk("t3_ready_full", job_ready, 0);
    chk("t3_busy_full", busy, 1);
    fcu_done = 1'b1;
    repeat (60) step();
    chk("t3_done_pulses", n_done - d0, 5);
    chk("t3_no_errors", n_err - e0, 0);
    chk("t3_last_width", last_w, 4);
    chk("t3_completed", jobs_completed, 8);
    chk("t3_idle_busy", busy, 0);

    // zero width: error, no FCU start
    s0 = n_start;
    push(0, 4, 2);
    wait_for(1, 5, cyc);
    chk("t4_done_latency", cyc, 2);
    chk("t4_job_error", job_error, 1);
    chk("t4_completed", jobs_completed, 8);
    chk("t4_no_start", n_start - s0, 0);

    // watchdog boundary: done in RUN cycle 100 succeeds, one cycle later fails
    cfg_timeout = 24'd100;
    fcu_done = 1'b0;
    push(6, 6, 2);
    wait_for(0, 5, cyc);
    chk("t5a_start", cyc, 1);
    repeat (102) step();
    fcu_done = 1'b1;
    wait_for(1, 5, cyc);
    chk("t5a_done_latency", cyc, 2);
    chk("t5a_job_error", job_error, 0);
    chk("t5a_completed", jobs_completed, 9);
    fcu_done = 1'b0;
    push(6, 6, 2);
    wait_for(0, 5, cyc);
    chk("t5b_start", cyc, 1);
    repeat (103) step();
    fcu_done = 1'b1;
    wait_for(1, 5, cyc);
    chk("t5b_done_latency", cyc, 2);
    chk("t5b_job_error", job_error, 1);
    fcu_done = 1'b0;
    push(6, 6, 2);
    wait_for(0, 5, cyc);
    repeat (300) step();
    chk("t5c_held_in_drain", busy, 1);
    fcu_done = 1'b1;
    wait_for(1, 5, cyc);
    chk("t5c_done_latency", cyc, 2);
    chk("t5c_job_error", job_error, 1);
    chk("t5c_completed", jobs_completed, 9);
    fcu_done = 1'b0;
    cfg_timeout = '0;

    // abort in LOAD_COEF with two jobs queued
    s0 = n_start;
    push(9, 9, 3);
    push(9, 9, 3);
    push(9, 9, 3);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    d0 = n_done;
    wait_for(1, 5, cyc);
    chk("t6_abort_done", cyc, 1);
    chk("t6_abort_error", job_error, 1);
    step();
    chk("t6_busy_clear", busy, 0);
    chk("t6_ready", job_ready, 1);
    repeat (20) step();
    chk("t6_single_done", n_done - d0, 1);
    chk("t6_no_start", n_start - s0, 0);

    // cache was invalidated: kernel 2 must be reloaded
    c0 = n_coef;
    push(7, 7, 2);
    wait_for(0, 20, cyc);
    chk("t6_reload_start", cyc, 11);
    chk("t6_reload_coefs", n_coef - c0, 9);

    // reset mid-RUN
    repeat (10) step();
    chk("t7_busy_run", busy, 1);
    resetn = 1'b0;
    #1;
    chk("t7_fcu_start", fcu_start, 0);
    chk("t7_fcu_width", fcu_width, 0);
    chk("t7_fcu_height", fcu_height, 0);
    chk("t7_job_done", job_done, 0);
    chk("t7_job_error", job_error, 0);
    chk("t7_completed", jobs_completed, 0);
    chk("t7_busy", busy, 0);
    chk("t7_job_ready", job_ready, 1);
    chk("t7_rom_addr", rom_addr, 0);
    chk("t7_coef_we", coef_we, 0);
    chk("t7_coef_idx", coef_idx, 0);
    chk("t7_coef_data", coef_data, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
